// File: rtl/frame_pingpong_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fb_pkg
// Description : Shared defaults and helpers for the ping-pong frame store.
//               DATA_W/H_RES/V_RES defaults, pixels-per-frame and address
//               width helpers, and the bank-offset address mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package fb_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int H_RES_DEF  = 320;
    localparam int V_RES_DEF  = 240;

    // Pixels in one frame.
    function automatic int pix_count(input int h_res, input int v_res);
        return h_res * v_res;
    endfunction

    // Bits needed to address one frame.
    function automatic int addr_width(input int h_res, input int v_res);
        return $clog2(h_res * v_res);
    endfunction

    // Bank 0 occupies [0, pix); bank 1 occupies [pix, 2*pix).
    function automatic int bank_offset(input logic bank, input int addr, input int pix);
        return bank ? (addr + pix) : addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_pingpong_buf_sdp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sdp_ram
// Description : Simple dual-port RAM, one write and one read port on a single
//               clock, registered read data. Contents are not reset so the
//               array maps onto block RAM.
// Ports       : clk      - clock
//               i_we     - write enable
//               i_waddr  - write address
//               i_wdata  - write data
//               i_re     - read enable
//               i_raddr  - read address
//               o_rdata  - read data, one cycle after i_re
// Revision    : 1.0 - initial release
// ============================================================================
module sdp_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/frame_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : frame_pingpong_buf
// Description : Double-buffered frame store between the camera capture path
//               and the VGA read path. A bank is published only once a full
//               frame has been written, and the displayed bank changes only at
//               a read frame start, so the display never shows a torn frame.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               wr_sof/valid/data    - capture side frame start and pixels
//               rd_sof/rd_en         - display frame start and pixel request
//               rd_data/rd_valid     - pixel, one cycle after rd_en
//               rd_bank/wr_bank      - displayed / filling bank
//               frame_ready          - sticky, a frame has been published
//               wr_overflow          - sticky, pixel arrived with no frame open
//               wr_short             - pulse, frame restarted before complete
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pingpong_buf
    import fb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int H_RES  = H_RES_DEF,
    parameter int V_RES  = V_RES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_sof,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_sof,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_bank,
    output logic              wr_bank,
    output logic              frame_ready,
    output logic              wr_overflow,
    output logic              wr_short
);

    localparam int              c_PIX  = pix_count(H_RES, V_RES);
    localparam int              c_AW   = addr_width(H_RES, V_RES);
    localparam int              c_RAW  = $clog2(2 * c_PIX);
    localparam logic [c_AW-1:0] c_LAST = c_AW'(c_PIX - 1);
    localparam logic [c_AW-1:0] c_ONE  = c_AW'(1);

    logic            r_rd_bank;
    logic            r_wr_bank;
    logic            r_wr_active;
    logic            r_pending;
    logic [c_AW-1:0] r_wr_addr;
    logic [c_AW-1:0] r_rd_addr;
    logic            r_rd_valid;
    logic            r_frame_ready;
    logic            r_wr_overflow;
    logic            r_wr_short;

    logic              w_wr_last;
    logic              w_swap;
    logic              w_rd_bank_nxt;
    logic              w_wr_bank_nxt;
    logic              w_wr_en;
    logic [c_AW-1:0]   w_wr_addr;
    logic [c_AW-1:0]   w_wr_addr_inc;
    logic [c_AW-1:0]   w_rd_addr;
    logic [c_AW-1:0]   w_rd_addr_inc;
    logic [c_RAW-1:0]  w_wr_phys;
    logic [c_RAW-1:0]  w_rd_phys;
    logic [DATA_W-1:0] w_ram_q;

    // Final pixel of an open frame. A wr_sof in the same cycle restarts the
    // frame instead, so the old frame cannot complete then.
    assign w_wr_last = wr_valid && r_wr_active && !wr_sof && (r_wr_addr == c_LAST);

    // A frame completing this cycle is as good as pending for the swap.
    assign w_swap        = rd_sof && (r_pending || w_wr_last);
    assign w_rd_bank_nxt = w_swap ? r_wr_bank : r_rd_bank;

    // New frames always fill the bank opposite the (post-swap) display bank.
    assign w_wr_bank_nxt = wr_sof ? ~w_rd_bank_nxt : r_wr_bank;

    assign w_wr_en       = wr_valid && (wr_sof || r_wr_active);
    assign w_wr_addr     = wr_sof ? '0 : r_wr_addr;
    assign w_wr_addr_inc = w_wr_addr + c_ONE;

    assign w_rd_addr     = rd_sof ? '0 : r_rd_addr;
    assign w_rd_addr_inc = (w_rd_addr == c_LAST) ? '0 : (w_rd_addr + c_ONE);

    assign w_wr_phys = c_RAW'(bank_offset(w_wr_bank_nxt, int'(w_wr_addr), c_PIX));
    assign w_rd_phys = c_RAW'(bank_offset(w_rd_bank_nxt, int'(w_rd_addr), c_PIX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank     <= 1'b0;
            r_wr_bank     <= 1'b1;
            r_wr_active   <= 1'b0;
            r_pending     <= 1'b0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_rd_valid    <= 1'b0;
            r_frame_ready <= 1'b0;
            r_wr_overflow <= 1'b0;
            r_wr_short    <= 1'b0;
        end else begin
            r_rd_bank <= w_rd_bank_nxt;
            r_wr_bank <= w_wr_bank_nxt;

            if (wr_sof) begin
                r_wr_active <= 1'b1;
            end else if (w_wr_last) begin
                r_wr_active <= 1'b0;
            end

            if (w_wr_en) begin
                r_wr_addr <= w_wr_addr_inc;
            end else if (wr_sof) begin
                r_wr_addr <= '0;
            end

            // A restart discards any unshown frame; a swap consumes it, and a
            // completion only becomes pending if it was not swapped in at once.
            if (wr_sof || w_swap) begin
                r_pending <= 1'b0;
            end else if (w_wr_last) begin
                r_pending <= 1'b1;
            end

            if (rd_en) begin
                r_rd_addr <= w_rd_addr_inc;
            end else if (rd_sof) begin
                r_rd_addr <= '0;
            end

            r_rd_valid <= rd_en;

            if (w_wr_last) begin
                r_frame_ready <= 1'b1;
            end

            if (wr_valid && !(wr_sof || r_wr_active)) begin
                r_wr_overflow <= 1'b1;
            end

            r_wr_short <= wr_sof && r_wr_active;
        end
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (2 * c_PIX),
        .ADDR_W (c_RAW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en && !rst),
        .i_waddr (w_wr_phys),
        .i_wdata (wr_data),
        .i_re    (rd_en && !rst),
        .i_raddr (w_rd_phys),
        .o_rdata (w_ram_q)
    );

    // The RAM is never cleared, so nothing is shown until a frame exists.
    assign rd_data     = (r_rd_valid && r_frame_ready) ? w_ram_q : '0;
    assign rd_valid    = r_rd_valid;
    assign rd_bank     = r_rd_bank;
    assign wr_bank     = r_wr_bank;
    assign frame_ready = r_frame_ready;
    assign wr_overflow = r_wr_overflow;
    assign wr_short    = r_wr_short;

endmodule
`default_nettype wire

// File: tb/tb_frame_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_pingpong_buf
// Description : Self-checking bench for frame_pingpong_buf with a 4x2 frame.
//               A frame-level model tracks displayed/pending/filling frame
//               contents; directed literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_pingpong_buf;

    localparam int DW = 12;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int P  = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_sof = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_sof = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_bank;
    logic          wr_bank;
    logic          frame_ready;
    logic          wr_overflow;
    logic          wr_short;

    frame_pingpong_buf #(
        .DATA_W (DW),
        .H_RES  (H),
        .V_RES  (V)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_sof      (wr_sof),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .rd_sof      (rd_sof),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .wr_bank     (wr_bank),
        .frame_ready (frame_ready),
        .wr_overflow (wr_overflow),
        .wr_short    (wr_short)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // ---------------- frame-level model ----------------
    logic [DW-1:0] m_disp [P];
    logic [DW-1:0] m_fill [P];
    logic [DW-1:0] m_pend [P];
    int            m_cnt, m_rd_idx;
    bit            m_filling, m_pend_v, m_known, m_rdb, m_wrb, m_ready, m_ovf;
    bit            m_live = 1'b0;
    bit            t_last, t_swap, t_complete, t_ovf;
    bit            e_valid, e_short, e_chk_data;
    logic [DW-1:0] e_data;

    always @(posedge clk) begin
        if (rst) begin
            m_rdb = 1'b0; m_wrb = 1'b1; m_filling = 1'b0; m_pend_v = 1'b0;
            m_cnt = 0; m_rd_idx = 0; m_ready = 1'b0; m_ovf = 1'b0; m_known = 1'b0;
            e_valid = 1'b0; e_short = 1'b0; e_chk_data = 1'b0; e_data = '0;
            m_live = 1'b1;
        end else begin
            t_complete = 1'b0;
            t_ovf  = wr_valid && !wr_sof && !m_filling;
            t_last = wr_valid && m_filling && !wr_sof && (m_cnt == P - 1);
            t_swap = rd_sof && (m_pend_v || t_last);
            e_short = wr_sof && m_filling;
            if (wr_valid && m_filling && !wr_sof) begin
                m_fill[m_cnt] = wr_data;
                m_cnt++;
                if (m_cnt == P) begin
                    m_filling  = 1'b0;
                    t_complete = 1'b1;
                end
            end
            if (t_swap) begin
                if (t_complete) m_disp = m_fill;
                else            m_disp = m_pend;
                m_rdb = m_wrb; m_pend_v = 1'b0; m_known = 1'b1;
            end
            if (t_complete) m_ready = 1'b1;
            if (t_complete && !t_swap) begin
                m_pend = m_fill; m_pend_v = 1'b1;
            end
            if (rd_sof) m_rd_idx = 0;
            e_valid = rd_en;
            if (rd_en) begin
                e_chk_data = !m_ready || m_known;
                e_data     = m_ready ? m_disp[m_rd_idx] : '0;
                m_rd_idx   = (m_rd_idx + 1) % P;
            end
            if (t_ovf) m_ovf = 1'b1;
            if (wr_sof) begin
                m_pend_v = 1'b0; m_wrb = !m_rdb; m_filling = 1'b1; m_cnt = 0;
                if (wr_valid) begin
                    m_fill[0] = wr_data; m_cnt = 1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_live) begin
            check("cmp_rd_valid", int'(rd_valid), int'(e_valid));
            if (e_valid && e_chk_data) check("cmp_rd_data", int'(rd_data), int'(e_data));
            check("cmp_rd_bank", int'(rd_bank), int'(m_rdb));
            check("cmp_wr_bank", int'(wr_bank), int'(m_wrb));
            check("cmp_frame_ready", int'(frame_ready), int'(m_ready));
            check("cmp_wr_overflow", int'(wr_overflow), int'(m_ovf));
            check("cmp_wr_short", int'(wr_short), int'(e_short));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit ws, input bit wv, input int wd, input bit rs, input bit re);
        wr_sof = ws; wr_valid = wv; wr_data = DW'(wd); rd_sof = rs; rd_en = re;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_rd_bank", int'(rd_bank), 0);
        check("reset_wr_bank", int'(wr_bank), 1);
        check("reset_rd_valid", int'(rd_valid), 0);

        // 1: reads before any frame give zero data
        for (int i = 0; i < P; i++) begin
            cyc(0, 0, 0, 0, 1);
            check("t1_rd_valid", int'(rd_valid), 1);
            check("t1_rd_data", int'(rd_data), 0);
        end
        cyc(0, 0, 0, 0, 0);
        check("t1_frame_ready", int'(frame_ready), 0);
        check("t1_rd_bank", int'(rd_bank), 0);

        // 2: first frame, then display it
        cyc(1, 1, 'h001, 0, 0);
        for (int i = 2; i <= P; i++) cyc(0, 1, i, 0, 0);
        cyc(0, 0, 0, 0, 0);
        check("t2_frame_ready", int'(frame_ready), 1);
        cyc(0, 0, 0, 1, 1);
        check("t2_rd_bank", int'(rd_bank), 1);
        check("t2_first_pix", int'(rd_data), 'h001);
        for (int i = 2; i <= P; i++) begin
            cyc(0, 0, 0, 0, 1);
            check("t2_pix", int'(rd_data), i);
        end

        // 3: second frame written while the first keeps being displayed
        cyc(1, 1, 'h101, 0, 1);
        check("t3_wr_bank", int'(wr_bank), 0);
        check("t3_old_pix", int'(rd_data), 'h001);
        for (int i = 2; i <= P; i++) begin
            cyc(0, 1, 'h100 + i, 0, 1);
            check("t3_old_pix", int'(rd_data), i);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        check("t3_rd_bank", int'(rd_bank), 0);
        check("t3_new_pix", int'(rd_data), 'h101);
        for (int i = 2; i <= P; i++) cyc(0, 0, 0, 0, 1);

        // 4: short frame is never published
        cyc(1, 1, 'h201, 0, 0);
        for (int i = 2; i <= 5; i++) cyc(0, 1, 'h200 + i, 0, 0);
        cyc(1, 0, 0, 0, 0);
        check("t4_wr_short", int'(wr_short), 1);
        cyc(0, 0, 0, 0, 0);
        check("t4_wr_short_end", int'(wr_short), 0);
        cyc(0, 0, 0, 1, 1);
        check("t4_rd_bank", int'(rd_bank), 0);
        check("t4_reread", int'(rd_data), 'h101);
        for (int i = 2; i <= P; i++) cyc(0, 0, 0, 0, 1);

        // 5: complete the restarted frame, then an orphan pixel
        for (int i = 1; i <= P; i++) cyc(0, 1, 'h300 + i, 0, 0);
        check("t5_no_ovf", int'(wr_overflow), 0);
        cyc(0, 1, 'hfff, 0, 0);
        check("t5_ovf", int'(wr_overflow), 1);
        cyc(0, 0, 0, 1, 1);
        check("t5_rd_bank", int'(rd_bank), 1);
        check("t5_pix0", int'(rd_data), 'h301);
        for (int i = 2; i <= P; i++) begin
            cyc(0, 0, 0, 0, 1);
            check("t5_pix", int'(rd_data), 'h300 + i);
        end
        check("t5_ovf_sticky", int'(wr_overflow), 1);

        // 6: rd_sof coincides with the final pixel; then reset mid-read
        cyc(1, 1, 'h401, 0, 0);
        for (int i = 2; i < P; i++) cyc(0, 1, 'h400 + i, 0, 0);
        cyc(0, 1, 'h408, 1, 1);
        check("t6_rd_bank", int'(rd_bank), 0);
        check("t6_pix0", int'(rd_data), 'h401);
        cyc(0, 0, 0, 0, 1);
        check("t6_pix1", int'(rd_data), 'h402);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 1);
        check("t6_rst_rd_valid", int'(rd_valid), 0);
        check("t6_rst_ovf", int'(wr_overflow), 0);
        check("t6_rst_ready", int'(frame_ready), 0);
        check("t6_rst_wr_bank", int'(wr_bank), 1);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
